ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Multi-cycle RV32M divider in the execute stage: DIV, DIVU, REM, REMU.
//  Radix-2 restoring iteration, one quotient bit per cycle.
//  Drives stallreq_o, which feeds the pipeline ctrl block's stallreq_from_ex_i.
//  ctrl freezes the pipeline while a division is in flight.
// PARAMETERS
//  WIDTH       32  operand/result width in bits (RV32)
//  CNT_W       $clog2(WIDTH)+1  iteration counter width
// PORTS
//  clk_i        in   1      clock; all state changes on its rising edge
//  rst_i        in   1      synchronous, active-high reset
//  start_i      in   1      EX holds a div/rem op; held high until valid_o
//  op_i         in   2      div_op_e: DIV=0, DIVU=1, REM=2, REMU=3
//  dividend_i   in   WIDTH  rs1; held stable by stall while busy
//  divisor_i    in   WIDTH  rs2; held stable by stall while busy
//  flush_i      in   1      kill in-flight op (branch/exception flush)
//  result_o     out  WIDTH  quotient or remainder; valid only when valid_o=1
//  valid_o      out  1      one-cycle pulse: result_o is final
//  stallreq_o   out  1      request pipeline stall (to ctrl)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, result_o=0, valid_o=0; stallreq_o=0 (rst_i dominates).
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//   - start_i & !flush_i: latch |dividend|, |divisor| (sign-corrected only for DIV/REM).
//   - Latch op, neg_q = sign(a)^sign(b), neg_r = sign(a).
//   - Special case divisor==0: q=all-ones, r=dividend; go to DONE.
//   - Special case DIV/REM with a=0x8000_0000, b=0xFFFF_FFFF: q=0x8000_0000, r=0; go to DONE.
//   - Otherwise cnt=WIDTH; go to BUSY.
//  BUSY: shift {rem,quo} left by 1; trial = rem - divisor.
//   - Trial non-negative: rem=trial, quo[0]=1. Else quo[0]=0.
//   - cnt-- each cycle; when cnt==1, go to DONE.
//  DONE: result_o = quo or rem, negated per neg_q/neg_r (2's complement, WIDTH bits).
//   - valid_o=1 for this cycle only; go to IDLE. start_i ignored in DONE.
//  stallreq_o (combinational) = !rst_i & !flush_i & ((IDLE & start_i) | BUSY).
//   - Low in DONE, so EX retires the op in the valid_o cycle.
//  Latency, normal op: start seen in cycle 0; BUSY cycles 1..32; valid_o in cycle 33.
//  Latency, special case: valid_o in cycle 1.
//  Back-to-back divides: the next op's start_i is taken in the IDLE cycle after DONE.
//  flush_i in any state: next state IDLE, valid_o=0, stallreq_o=0 that cycle.
//   - A result in DONE with flush_i is suppressed (valid_o=0).
//  rst_i mid-operation: same as reset; partial state discarded.
//  result_o holds its last value outside DONE; the bench checks it only under valid_o.
// CONFIGURATION
//  Macro DIV_EARLY_OUT_EN:
//   - Defined: in IDLE, a normal op with |dividend| < |divisor| (unsigned magnitudes)
//     goes straight to DONE with q=0, r=dividend. valid_o in cycle 1.
//   - Undefined: such ops take the full 32 iterations with identical results.
//  Special cases (div-by-zero, overflow) are fast in both builds.
// STRUCTURE
//  Shared package milano_pkg: div_op_e enum, div_state_e enum (IDLE/BUSY/DONE).
//  Sub-module div_step (combinational): one restoring step.
//   - Inputs: rem, quo, divisor. Outputs: rem_nxt, quo_nxt.
//   - Instantiated once; also usable standalone in unit tests.
// TESTING
//  1 DIVU 100/7, start held -> stallreq_o high cycles 0-32; valid_o cycle 33; result 14.
//  2 REM -7/2 -> result 0xFFFF_FFFF (-1); DIV -7/2 -> 0xFFFF_FFFD (-3).
//  3 DIV 5/0 -> valid_o cycle 1, result 0xFFFF_FFFF; REMU 5/0 -> result 5.
//  4 DIV 0x8000_0000/0xFFFF_FFFF -> result 0x8000_0000; REM of same -> 0, both in cycle 1.
//  5 flush_i in BUSY cycle 10 -> next cycle IDLE, stallreq_o=0, no valid_o;
//    a new DIVU 9/3 then gives 3 at cycle 33.
//  6 DIVU 3/10, DIV_EARLY_OUT_EN defined -> valid_o cycle 1, result 0;
//    undefined -> cycle 33, result 0. rst_i in BUSY -> IDLE, outputs 0.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types for the execute-stage divider: operation and FSM state encodings.
// Helper functions classify an operation as signed and/or remainder-producing.
package milano_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract the divisor if it fits.
// Purely combinational so it can be unit-tested on its own.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_nxt_o,
    output logic [WIDTH-1:0] quo_nxt_o
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_trial;
    logic             w_fits;
    logic             w_unused;

    // The shifted remainder can reach 2*divisor-1, so one extra bit plus a sign bit is needed.
    assign w_shifted = {rem_i, quo_i[WIDTH-1]};
    assign w_trial   = {1'b0, w_shifted} - {2'b00, divisor_i};
    assign w_fits    = ~w_trial[WIDTH+1];

    assign rem_nxt_o = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign quo_nxt_o = {quo_i[WIDTH-2:0], w_fits};

    // Upper bits are provably zero in whichever branch is selected.
    assign w_unused = ^{w_trial[WIDTH], w_shifted[WIDTH]};

endmodule

// File: rtl/ex_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module ex_div
    import milano_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic             stallreq_o,
    output logic [1:0]       dbg_state_o
);

    // Handshake: start_i is held by EX until the one-cycle valid_o pulse; stallreq_o
    // freezes the pipeline meanwhile and drops in DONE so EX retires in the valid_o cycle.

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_op;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_early;
    logic             w_fast;
    logic             w_take;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;
    logic [WIDTH-1:0] w_final;

    assign w_signed   = op_is_signed(op_i);
    assign w_a_neg    = w_signed & dividend_i[WIDTH-1];
    assign w_b_neg    = w_signed & divisor_i[WIDTH-1];
    assign w_abs_a    = w_a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign w_abs_b    = w_b_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign w_div_zero = (divisor_i == '0);
    assign w_overflow = w_signed & (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                      & (divisor_i == '1);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    assign w_fast = w_div_zero | w_overflow | w_early;
    assign w_take = start_i & ~flush_i;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (r_rem),
        .quo_i     (r_quo),
        .divisor_i (r_divisor),
        .rem_nxt_o (w_rem_nxt),
        .quo_nxt_o (w_quo_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_nxt = w_fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = IDLE;
        end
    end

    // Fast paths load the final quotient/remainder directly with no sign fix-up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_op      <= 2'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_op <= op_i;
                        if (w_div_zero) begin
                            r_quo   <= '1;
                            r_rem   <= dividend_i;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_overflow) begin
                            r_quo   <= {1'b1, {(WIDTH-1){1'b0}}};
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_early) begin
                            r_quo   <= '0;
                            r_rem   <= dividend_i;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_quo     <= w_abs_a;
                            r_rem     <= '0;
                            r_divisor <= w_abs_b;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                            r_cnt     <= CNT_W'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    if (!flush_i) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!flush_i) begin
                        r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_q_final = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_final = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    assign w_final   = op_is_rem(r_op) ? w_r_final : w_q_final;

    assign result_o    = (r_state == DONE) ? w_final : r_result;
    assign valid_o     = (r_state == DONE) & ~flush_i & ~rst_i;
    assign stallreq_o  = ~rst_i & ~flush_i
                       & (((r_state == IDLE) & start_i) | (r_state == BUSY));
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: table of vectors plus flush/reset sequences.
// Expected latency of early-out candidates follows DIV_EARLY_OUT_EN.
module tb_ex_div;
    import milano_pkg::*;

    localparam int WIDTH = 32;
    localparam int K_NORM = 0;
    localparam int K_SPEC = 1;
    localparam int K_EARLY = 2;
`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
        int               kind;
    } vec_t;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             flush_i;
    logic [WIDTH-1:0] result_o;
    logic             valid_o;
    logic             stallreq_o;
    logic [1:0]       dbg_state_o;

    int               n_tests;
    int               n_fail;
    logic [WIDTH-1:0] exp_q[$];
    vec_t             vecs[21];

    ex_div #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .flush_i     (flush_i),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .stallreq_o  (stallreq_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one op from an idle cycle and scores latency, stall pattern and result.
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input int exp_lat, input string name);
        int               cyc;
        logic             got;
        logic             stall_bad;
        logic [WIDTH-1:0] exp_res;
        @(posedge clk_i); #1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        #1;
        stall_bad = ~stallreq_o;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk_i); #1;
            cyc++;
            if (valid_o) got = 1'b1;
            else if (!stallreq_o) stall_bad = 1'b1;
        end
        start_i = 1'b0;
        exp_res = exp_q.pop_front();
        check({name, " valid seen"}, WIDTH'(got), WIDTH'(1));
        if (got) begin
            check({name, " latency"}, WIDTH'(cyc), WIDTH'(exp_lat));
            check({name, " stall before done"}, WIDTH'(stall_bad), WIDTH'(0));
            check({name, " stall in done"}, WIDTH'(stallreq_o), WIDTH'(0));
            check({name, " result"}, result_o, exp_res);
            @(posedge clk_i); #1;
            check({name, " valid pulse"}, WIDTH'(valid_o), WIDTH'(0));
        end
    endtask

    function automatic int lat_of(input int kind);
        if (kind == K_NORM) return 33;
        if (kind == K_SPEC) return 1;
        return EARLY_LAT;
    endfunction

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_i      = 1'b1;
        start_i    = 1'b1;
        op_i       = DIVU;
        dividend_i = '0;
        divisor_i  = '0;
        flush_i    = 1'b0;

        vecs = '{
            '{DIVU, 32'd100,        32'd7,          32'd14,         K_NORM},
            '{REMU, 32'd100,        32'd7,          32'd2,          K_NORM},
            '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  K_NORM},
            '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  K_NORM},
            '{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  K_SPEC},
            '{REMU, 32'd5,          32'd0,          32'd5,          K_SPEC},
            '{REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  K_SPEC},
            '{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  K_SPEC},
            '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  K_SPEC},
            '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          K_SPEC},
            '{DIVU, 32'd3,          32'd10,         32'd0,          K_EARLY},
            '{REMU, 32'd3,          32'd10,         32'd3,          K_EARLY},
            '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  K_NORM},
            '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          K_NORM},
            '{DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          K_NORM},
            '{REM,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  K_NORM},
            '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  K_NORM},
            '{REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          K_NORM},
            '{DIV,  32'h8000_0000,  32'h8000_0000,  32'd1,          K_NORM},
            '{REM,  32'hFFFF_FFF9,  32'd10,         32'hFFFF_FFF9,  K_EARLY},
            '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          K_EARLY}
        };

        // Reset: start_i high must not raise a stall while rst_i is asserted.
        repeat (3) @(posedge clk_i);
        #1;
        check("reset stall", WIDTH'(stallreq_o), WIDTH'(0));
        check("reset valid", WIDTH'(valid_o), WIDTH'(0));
        check("reset result", result_o, '0);
        check("reset state", WIDTH'(dbg_state_o), WIDTH'(IDLE));
        start_i = 1'b0;
        rst_i   = 1'b0;

        for (int i = 0; i < 21; i++) begin
            exp_q.push_back(vecs[i].exp);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat_of(vecs[i].kind),
                   $sformatf("vec%0d", i));
        end

        // Flush in BUSY cycle 10, then a fresh DIVU 9/3.
        @(posedge clk_i); #1;
        op_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        check("flush pre state", WIDTH'(dbg_state_o), WIDTH'(BUSY));
        flush_i = 1'b1;
        start_i = 1'b0;
        #1;
        check("flush stall", WIDTH'(stallreq_o), WIDTH'(0));
        check("flush valid", WIDTH'(valid_o), WIDTH'(0));
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        #1;
        check("flush next state", WIDTH'(dbg_state_o), WIDTH'(IDLE));
        check("flush next valid", WIDTH'(valid_o), WIDTH'(0));
        check("flush next stall", WIDTH'(stallreq_o), WIDTH'(0));
        exp_q.push_back(32'd3);
        run_op(DIVU, 32'd9, 32'd3, 33, "divu 9/3 after flush");

        // Flush arriving in DONE suppresses the result.
        @(posedge clk_i); #1;
        op_i = DIV; dividend_i = 32'd5; divisor_i = 32'd0; start_i = 1'b1;
        @(posedge clk_i); #1;
        check("done flush pre state", WIDTH'(dbg_state_o), WIDTH'(DONE));
        flush_i = 1'b1;
        start_i = 1'b0;
        #1;
        check("done flush valid", WIDTH'(valid_o), WIDTH'(0));
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("done flush next state", WIDTH'(dbg_state_o), WIDTH'(IDLE));
        check("done flush next valid", WIDTH'(valid_o), WIDTH'(0));

        // Reset in BUSY discards the op and clears the held result.
        @(posedge clk_i); #1;
        op_i = DIVU; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("busy reset stall", WIDTH'(stallreq_o), WIDTH'(0));
        check("busy reset valid", WIDTH'(valid_o), WIDTH'(0));
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        check("post reset state", WIDTH'(dbg_state_o), WIDTH'(IDLE));
        check("post reset result", result_o, '0);
        check("post reset valid", WIDTH'(valid_o), WIDTH'(0));
        check("post reset stall", WIDTH'(stallreq_o), WIDTH'(0));
        exp_q.push_back(32'd2);
        run_op(REMU, 32'd100, 32'd7, 33, "remu after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
